// File: rtl/mont_pkg.sv
// mont_pkg: shared state encoding, default width and counter-width helper for the Montgomery multiplier
package mont_pkg;

    typedef enum logic [1:0] {IDLE, ITER, SUB, DONE} montState_t;

    localparam int DEF_WIDTH = 512;

    // Smallest r with 2^r >= v
    function automatic int clog2(input int v);
        int r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/mont_iter_step.sv
// mont_iter_step: one radix-2 Montgomery iteration, cNext = (c + a*b + q*m) / 2 with q making the sum even
//   c     in   WIDTH+2  running accumulator (< 2m for legal operands)
//   b     in   WIDTH    multiplier
//   m     in   WIDTH    odd modulus
//   a     in   1        current multiplicand bit
//   cNext out  WIDTH+2  accumulator after this iteration
module mont_iter_step import mont_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH+1:0] c,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    input  logic             a,
    output logic [WIDTH+1:0] cNext
);

    logic [WIDTH+1:0] t;
    logic [WIDTH+1:0] u;

    // Two extra bits keep c + b + m below 2^(WIDTH+2) even for out-of-range operands
    always_comb begin
        t = c + (a ? {2'b00, b} : '0);
        u = t[0] ? t + {2'b00, m} : t;
        cNext = u >> 1;
    end

endmodule

// File: rtl/montgomery_mul_param.sv
// montgomery_mul_param: bit-serial radix-2 Montgomery multiplier, result = A*B*2^-WIDTH mod M
//   clk/reset              clock, asynchronous active-high reset
//   in_valid/in_ready      operand handshake (ready only in IDLE)
//   in_a, in_b, in_m       operands, sampled on the accept edge only
//   abort                  cancels an operation in ITER/SUB/DONE
//   out_valid/out_ready    result handshake, result/err held until accepted
//   result, err            reduced product; err=1 flags an even modulus (result 0)
//   busy                   high while iterating or subtracting
module montgomery_mul_param import mont_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             err,
    output logic             busy
);

    localparam int CNT_W = clog2(WIDTH);

    montState_t state, stateNext;
    logic [WIDTH-1:0] aReg, bReg, mReg, diff;
    logic [WIDTH+1:0] cReg, cNext;
    logic [CNT_W-1:0] cnt;
    logic accept, lastIter, borrow;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign busy      = state == ITER || state == SUB;
    // abort in IDLE blocks a simultaneous accept
    assign accept    = in_valid && in_ready && !abort;
    assign lastIter  = cnt == CNT_W'(WIDTH - 1);
    // C < 2M, so the low WIDTH bits of C - M are exact whenever no borrow occurs
    assign borrow    = cReg < {2'b00, mReg};
    assign diff      = cReg[WIDTH-1:0] - mReg;

    mont_iter_step #(.WIDTH(WIDTH)) step (
        .c     (cReg),
        .b     (bReg),
        .m     (mReg),
        .a     (aReg[0]),
        .cNext (cNext)
    );

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (accept) stateNext = in_m[0] ? ITER : DONE;
            ITER:    if (lastIter) stateNext = SUB;
            SUB:     stateNext = DONE;
            DONE:    if (out_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
        if (abort) stateNext = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            aReg   <= '0;
            bReg   <= '0;
            mReg   <= '0;
            cReg   <= '0;
            cnt    <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                aReg   <= in_a;
                bReg   <= in_b;
                mReg   <= in_m;
                cReg   <= '0;
                cnt    <= '0;
                result <= '0;
                err    <= ~in_m[0];
            end
            if (state == ITER && !abort) begin
                cReg <= cNext;
                aReg <= aReg >> 1;
                cnt  <= cnt + 1'b1;
            end
            if (state == SUB && !abort) begin
                result <= borrow ? cReg[WIDTH-1:0] : diff;
                err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_mul_param.sv
// tb_montgomery_mul_param: directed and random checks of the Montgomery multiplier at WIDTH=8 and WIDTH=512
module tb_montgomery_mul_param;

    localparam int W  = 8;
    localparam int WL = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic inValid = 1'b0, inReady, abort = 1'b0, outValid, outReady = 1'b0, err, busy;
    logic [W-1:0] inA = '0, inB = '0, inM = '0, result;

    logic lInValid = 1'b0, lInReady, lAbort = 1'b0, lOutValid, lOutReady = 1'b0, lErr, lBusy;
    logic [WL-1:0] lA = '0, lB = '0, lM = '0, lResult;

    int total = 0;
    int bad = 0;

    montgomery_mul_param #(.WIDTH(W)) dut8 (
        .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
        .in_a(inA), .in_b(inB), .in_m(inM), .abort(abort),
        .out_valid(outValid), .out_ready(outReady), .result(result), .err(err), .busy(busy)
    );

    montgomery_mul_param #(.WIDTH(WL)) dut512 (
        .clk(clk), .reset(reset), .in_valid(lInValid), .in_ready(lInReady),
        .in_a(lA), .in_b(lB), .in_m(lM), .abort(lAbort),
        .out_valid(lOutValid), .out_ready(lOutReady), .result(lResult), .err(lErr), .busy(lBusy)
    );

    task automatic check(input string tag, input logic [WL-1:0] got, input logic [WL-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent small-width reference: a*b*inv(256) mod m
    function automatic int ref8(input int a, input int b, input int m);
        int inv = 0;
        for (int r = 1; r < m; r++)
            if ((r * 256) % m == 1) inv = r;
        return ((a * b) % m) * inv % m;
    endfunction

    function automatic logic [WL-1:0] rnd512();
        logic [WL-1:0] v;
        for (int i = 0; i < WL / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run8(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] m, input logic [W-1:0] expR, input logic expE,
                        input int expLat, input int hold);
        int lat = 0;
        @(negedge clk);
        check({tag, "_rdy"}, inReady, 1);
        inA = a; inB = b; inM = m; inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        inValid = 1'b0; inA = '1; inB = '1; inM = '0;
        check({tag, "_busy"}, busy, expE ? 1'b0 : 1'b1);
        while (!outValid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, lat, expLat);
        check({tag, "_res"}, result, expR);
        check({tag, "_err"}, err, expE);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_bp_valid"}, outValid, 1);
            check({tag, "_bp_rdy"}, inReady, 0);
            check({tag, "_bp_res"}, result, expR);
            check({tag, "_bp_err"}, err, expE);
        end
        @(negedge clk);
        outReady = 1'b1;
        @(posedge clk); #1;
        outReady = 1'b0;
        check({tag, "_drop"}, outValid, 0);
        check({tag, "_idle"}, inReady, 1);
    endtask

    task automatic run512(input logic [WL-1:0] a, input logic [WL-1:0] b, input logic [WL-1:0] m);
        int lat = 0;
        logic [2*WL-1:0] lhs, rhs, mw;
        @(negedge clk);
        lA = a; lB = b; lM = m; lInValid = 1'b1; lOutReady = 1'b0;
        @(posedge clk); #1;
        lInValid = 1'b0;
        while (!lOutValid && lat < 2000) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w512_lat", lat, WL + 1);
        check("w512_err", lErr, 0);
        check("w512_lt_m", lResult < m, 1);
        // result*2^512 == a*b (mod m) with result < m pins down the unique answer
        mw  = {{WL{1'b0}}, m};
        lhs = ({{WL{1'b0}}, lResult} << WL) % mw;
        rhs = ({{WL{1'b0}}, a} * {{WL{1'b0}}, b}) % mw;
        check("w512_res", lhs[WL-1:0], rhs[WL-1:0]);
        @(negedge clk);
        lOutReady = 1'b1;
        @(posedge clk); #1;
        lOutReady = 1'b0;
    endtask

    initial begin
        logic [WL-1:0] a, b, m;
        int ra, rb, rm;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", inReady, 1);
        check("rst_out_valid", outValid, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        run8("mul_5_7", 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, W + 1, 0);
        run8("mul_12_12", 8'd12, 8'd12, 8'd13, 8'd3, 1'b0, W + 1, 0);
        run8("mul_0_7", 8'd0, 8'd7, 8'd13, 8'd0, 1'b0, W + 1, 0);
        run8("even_m", 8'd5, 8'd7, 8'd12, 8'd0, 1'b1, 0, 0);
        run8("backpr", 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, W + 1, 20);
        run8("even_bp", 8'd3, 8'd4, 8'd100, 8'd0, 1'b1, 0, 3);

        // abort in IDLE together with in_valid: not accepted
        @(negedge clk);
        inA = 8'd5; inB = 8'd7; inM = 8'd13; inValid = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        check("abort_idle_rdy", inReady, 1);
        check("abort_idle_busy", busy, 0);
        @(negedge clk);
        abort = 1'b0;
        @(posedge clk); #1;
        check("abort_acc_busy", busy, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk); #1;
        check("abort_iter_rdy", inReady, 1);
        check("abort_iter_busy", busy, 0);
        check("abort_iter_ov", outValid, 0);
        @(negedge clk);
        abort = 1'b0; inValid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("abort_no_result", outValid, 0);
        run8("post_abort", 8'd5, 8'd7, 8'd13, 8'd1, 1'b0, W + 1, 0);

        // abort in DONE with out_ready: back to IDLE, no result
        @(negedge clk);
        inA = 8'd12; inB = 8'd12; inM = 8'd13; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (W + 1) @(posedge clk);
        #1;
        check("done_ov", outValid, 1);
        @(negedge clk);
        abort = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; outReady = 1'b0;
        check("done_abort_ov", outValid, 0);
        check("done_abort_rdy", inReady, 1);

        // reset mid-ITER
        @(negedge clk);
        inA = 8'd9; inB = 8'd11; inM = 8'd13; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_rdy", inReady, 1);
        check("mid_rst_ov", outValid, 0);
        check("mid_rst_res", result, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;
        run8("post_rst", 8'd9, 8'd11, 8'd13, 8'(ref8(9, 11, 13)), 1'b0, W + 1, 0);

        for (int i = 0; i < 20; i++) begin
            rm = $urandom_range(3, 255) | 1;
            ra = $urandom_range(0, rm - 1);
            rb = $urandom_range(0, rm - 1);
            run8("rand8", 8'(ra), 8'(rb), 8'(rm), 8'(ref8(ra, rb, rm)), 1'b0, W + 1, 0);
        end

        for (int i = 0; i < 60; i++) begin
            m = rnd512();
            m[WL-1] = 1'b1;
            m[0] = 1'b1;
            a = rnd512() % m;
            b = rnd512() % m;
            if (i == 0) b = m - 1;
            run512(a, b, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
